// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
//
// Responds to the cache's line-level pmem handshake. It converts each full-line read or write
// into a multi-beat burst on the narrow physical-memory bus. When the burst finishes, it
// returns a single-cycle line response.
//
// Cache side:
//   line_i     write line from cache
//   line_o     read line to cache (always driven from the line buffer)
//   address_i  line request address
//   read_i     line read request, held until resp_o
//   write_i    line write request, held until resp_o
//   resp_o     one-cycle line completion pulse
// Memory side:
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned burst address
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     beat valid (read) / beat accepted (write)
// clk, rst: rst is a synchronous, active-high reset.
module cacheline_burst_adaptor #(
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BEATS*BEAT_WIDTH-1:0]   line_i,
  output logic [BEATS*BEAT_WIDTH-1:0]   line_o,
  input  logic [ADDR_WIDTH-1:0]         address_i,
  input  logic                          read_i,
  input  logic                          write_i,
  output logic                          resp_o,
  input  logic [BEAT_WIDTH-1:0]         burst_i,
  output logic [BEAT_WIDTH-1:0]         burst_o,
  output logic [ADDR_WIDTH-1:0]         address_o,
  output logic                          read_o,
  output logic                          write_o,
  input  logic                          resp_i
);

  localparam int unsigned LineWidth = BEATS * BEAT_WIDTH;
  localparam int unsigned OffW      = $clog2(LineWidth / 8);
  localparam int unsigned CntW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                state;
  logic [CntW-1:0]       cnt;
  logic [LineWidth-1:0]  buffer;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  assign aligned_addr = {address_i[ADDR_WIDTH-1:OffW], OffW'(0)};
  assign line_o       = buffer;
  // Only present a beat while a write burst is active; otherwise the bus stays quiet.
  assign burst_o      = write_o ? buffer[cnt*BEAT_WIDTH +: BEAT_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      buffer    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      unique case (state)
        StIdle: begin
          // Read has priority when both requests are raised together.
          if (read_i) begin
            address_o <= aligned_addr;
            read_o    <= 1'b1;
            state     <= StRead;
          end else if (write_i) begin
            address_o <= aligned_addr;
            buffer    <= line_i;
            write_o   <= 1'b1;
            state     <= StWrite;
          end
        end
        StRead: begin
          if (resp_i) begin
            buffer[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
            if (cnt == LastBeat) begin
              cnt    <= '0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= StDone;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end
        StWrite: begin
          if (resp_i) begin
            if (cnt == LastBeat) begin
              cnt     <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= StDone;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int vectors    = 0;
  int miscompares = 0;

  cacheline_burst_adaptor #(
    .BEAT_WIDTH(64),
    .BEATS     (4),
    .ADDR_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0]  rb [4];
  logic [63:0]  bb [4];
  logic [63:0]  wb [4];
  logic [255:0] saved;
  bit           pat [7];

  initial begin
    rb[0] = 64'h1111_1111_1111_1111; rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333; rb[3] = 64'h4444_4444_4444_4444;
    bb[0] = 64'h0123_4567_89AB_CDEF; bb[1] = 64'hFEDC_BA98_7654_3210;
    bb[2] = 64'h5A5A_5A5A_A5A5_A5A5; bb[3] = 64'h0F0F_0F0F_F0F0_F0F0;
    wb[0] = 64'hAAAA_AAAA_AAAA_AAAA; wb[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wb[2] = 64'hCCCC_CCCC_CCCC_CCCC; wb[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_line_o", line_o, '0);
    chk("rst_outs", {burst_o, address_o, read_o, write_o, resp_o}, '0);
    rst = 1'b0;
    tick();

    // Contiguous read
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick(); // T1
    chk("rd_addr", address_o, 32'h0000_1220);
    chk("rd_read_o", read_o, 1);
    chk("rd_write_o", write_o, 0);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = rb[i];
      tick();
      chk("rd_resp_o", resp_o, (i == 3) ? 1 : 0);
    end
    chk("rd_read_o_done", read_o, 0);
    chk("rd_line", line_o, {rb[3], rb[2], rb[1], rb[0]});
    read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
    tick();
    chk("rd_resp_pulse", resp_o, 0);
    tick();

    // Read with bubbles: 1,0,0,1,1,0,1
    read_i = 1'b1; address_i = 32'h0000_0100;
    tick(); // T1
    chk("bub_read_o", read_o, 1);
    for (int i = 0, k = 0; i < 7; i++) begin
      resp_i = pat[i];
      burst_i = pat[i] ? bb[k] : 64'hFFFF_FFFF_FFFF_FFFF;
      if (pat[i]) k++;
      tick();
      chk("bub_resp_o", resp_o, (i == 6) ? 1 : 0);
    end
    chk("bub_line", line_o, {bb[3], bb[2], bb[1], bb[0]});
    read_i = 1'b0; resp_i = 1'b0;
    tick(); tick();

    // Write
    write_i = 1'b1; address_i = 32'h8000_0040; line_i = {wb[3], wb[2], wb[1], wb[0]};
    tick(); // T1
    line_i = '1; address_i = 32'hFFFF_FFFF; // must be ignored after latch
    chk("wr_write_o", write_o, 1);
    chk("wr_read_o", read_o, 0);
    chk("wr_addr", address_o, 32'h8000_0040);
    chk("wr_beat0_hold", burst_o, wb[0]);
    tick(); // one stall cycle without resp_i
    chk("wr_beat0_stall", burst_o, wb[0]);
    for (int i = 0; i < 4; i++) begin
      chk("wr_beat", burst_o, wb[i]);
      resp_i = 1'b1;
      tick();
      chk("wr_resp_o", resp_o, (i == 3) ? 1 : 0);
    end
    chk("wr_write_o_done", write_o, 0);
    chk("wr_line_o", line_o, {wb[3], wb[2], wb[1], wb[0]});
    write_i = 1'b0; resp_i = 1'b0;
    tick(); tick();

    // Simultaneous read and write request: read wins
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0040;
    tick();
    chk("sim_read_o", read_o, 1);
    chk("sim_write_o", write_o, 0);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = rb[3 - i];
      tick();
      chk("sim_write_never", write_o, 0);
    end
    chk("sim_resp_o", resp_o, 1);
    chk("sim_line", line_o, {rb[0], rb[1], rb[2], rb[3]});
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    tick();
    chk("sim_resp_once", resp_o, 0);
    tick();

    // Reset mid-burst after 2 beats
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick();
    resp_i = 1'b1; burst_i = rb[0]; tick();
    burst_i = rb[1]; tick();
    rst = 1'b1; resp_i = 1'b0;
    tick();
    chk("mid_rst_line", line_o, '0);
    chk("mid_rst_outs", {burst_o, address_o, read_o, write_o, resp_o}, '0);
    rst = 1'b0;
    tick(); // IDLE, read_i still high -> new read
    chk("mid_new_read", read_o, 1);
    chk("mid_new_addr", address_o, 32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = bb[i];
      tick();
      chk("mid_resp_o", resp_o, (i == 3) ? 1 : 0);
    end
    chk("mid_line", line_o, {bb[3], bb[2], bb[1], bb[0]});

    // Held request: read_i still high after resp_o; resp_i in IDLE ignored
    saved = {bb[3], bb[2], bb[1], bb[0]};
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick(); // IDLE cycle
    chk("held_idle_read_o", read_o, 0);
    chk("held_idle_resp_o", resp_o, 0);
    resp_i = 1'b0;
    tick(); // two cycles after resp_o
    chk("held_read_o", read_o, 1);
    chk("held_line_kept", line_o, saved);
    read_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = rb[i];
      tick();
    end
    chk("held_resp_o", resp_o, 1);
    chk("held_line", line_o, {rb[3], rb[2], rb[1], rb[0]});
    resp_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Run bound in case of a hang in the DUT handshake.
  initial begin
    #100000;
    $display("FAIL timeout: observed no end of run, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the cache pmem handshake (pmem_read/pmem_write, pmem_address, pmem_rdata/pmem_wdata, pmem_resp).
- Services each full cache-line request as a multi-beat burst on the narrow physical-memory bus.
- Returns a single-cycle line-level response to the cache.
- Sits between the I-/D-cache (or their arbiter) and the DRAM model.

Parameters:
BEAT_WIDTH, 64, data bits per memory beat
BEATS, 4, beats per cache line; line width = BEATS*BEAT_WIDTH = 256
ADDR_WIDTH, 32, address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
line_i  in  256  write line from cache
line_o  out  256  read line to cache
address_i  in  32  line request address from cache
read_i  in  1  cache line read request, held until resp_o
write_i  in  1  cache line write request, held until resp_o
resp_o  out  1  one-cycle line completion pulse
burst_i  in  64  read beat from memory
burst_o  out  64  write beat to memory
address_o  out  32  line-aligned burst address to memory
read_o  out  1  burst read request
write_o  out  1  burst write request
resp_i  in  1  memory beat valid/accepted

Behaviour:
- Clock and reset: clk; rst is synchronous, active-high.
- Reset values:
  - All outputs 0: line_o, burst_o, address_o, read_o, write_o, resp_o.
  - Internal line buffer 0, beat counter 0, state IDLE.
  - Reset wins over every other event, including mid-burst; the partial burst is abandoned.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1: latch address_i with [4:0] forced to 0; go READ.
  - else write_i=1: latch address, latch line_i into buffer; go WRITE.
  - read_i and write_i both high: read wins, write_i ignored.
  - resp_i ignored.
- READ:
  - read_o=1; address_o = latched aligned address, held stable.
  - Each cycle with resp_i=1: buffer[cnt*64 +: 64] <= burst_i; cnt++.
  - resp_i=0 cycles are bubbles: no capture, cnt holds.
  - On the beat where cnt==BEATS-1: cnt<=0, go DONE.
- WRITE:
  - write_o=1; address_o as in READ; burst_o = buffer[cnt*64 +: 64] (combinational from cnt).
  - Each cycle with resp_i=1 means the beat is accepted: cnt++.
  - Last accepted beat: cnt<=0, go DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; go IDLE.
- line_o: always driven from the buffer.
  - Valid in the DONE cycle after a read.
  - Stable until the next read's first captured beat.
  - Writes do not change line_o's contents relative to the line just written.
- Requester contract: read_i/write_i must be low in the cycle after resp_o.
  - If still high, it is treated as a new request, with one IDLE cycle between requests minimum.
- address_i/line_i changes after the IDLE latch cycle are ignored until the next request.
- Latency:
  - Request seen at T0 (IDLE); read_o/write_o high from T1.
  - With resp_i high T1..T4, resp_o is at T5.
  - General: 2 + BEATS + (bubble cycles).
- read_o and write_o are never high together; resp_o never coincides with read_o or write_o.
- Beat counter is $clog2(BEATS) bits and wraps only via explicit clear.

Test Plan:
- Contiguous read, reset released, read_i=1, address_i=0x0000_1234:
  - address_o=0x0000_1220 and read_o=1 from T1.
  - resp_i=1 T1..T4 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - resp_o=1 only at T5; line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with bubbles, resp_i pattern 1,0,0,1,1,0,1:
  - Four beats captured in order, no capture on 0-cycles.
  - resp_o one cycle after the 4th beat; total latency 9.
- Write, line_i=0xDDDD..._CCCC..._BBBB..._AAAA..., address_i=0x8000_0040:
  - write_o=1, burst_o=0xAAAA... until the first resp_i.
  - Then 0xBBBB..., 0xCCCC..., 0xDDDD....
  - resp_o one cycle after the 4th accept; write_o low in DONE.
- Simultaneous request: read_i=write_i=1 in IDLE -> read burst only (read_o=1, write_o never 1); resp_o once.
- Reset mid-burst: rst=1 after 2 read beats:
  - Next cycle all outputs 0, state IDLE.
  - A subsequent read requires 4 fresh beats, with no stale beat count.
- Held request: read_i still high the cycle after resp_o -> new read issues (read_o=1 two cycles after resp_o); resp_i while IDLE does not alter line_o.
